// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared MDU definitions: opcodes, issue FSM states, default latencies.
// Also imported by the multiply/divide unit so both sides agree on encodings.
package mdu_issue_ctrl_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    localparam int MULT_T_DEF = 5;
    localparam int DIV_T_DEF  = 10;
    localparam int CNT_W      = 8;

    function automatic logic is_mul(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_mt(input logic [3:0] op);
        return (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

    // Any real MDU-class opcode; encodings above MFLO are treated as NONE.
    function automatic logic is_md(input logic [3:0] op);
        return (op != OP_NONE) && (op <= OP_MFLO);
    endfunction

endpackage

// File: rtl/mdu_lat_counter.sv
// Occupancy down-counter for the MDU issue FSM.
// Loads a start value, counts down to zero and holds there.
module mdu_lat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load has priority over decrement; saturate at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mdu_issue_ctrl.sv
// E-stage issue control for the multiply/divide unit.
// Sequences IDLE -> ISSUE -> RUN -> COMMIT and stalls MDU consumers.
module mdu_issue_ctrl
    import mdu_issue_ctrl_pkg::*;
#(
    parameter int MULT_T = MULT_T_DEF,
    parameter int DIV_T  = DIV_T_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid_i,
    input  logic [3:0]  e_op_i,
    input  logic [31:0] e_rs_i,
    input  logic [31:0] e_rt_i,
    input  logic        d_md_i,
    output logic        mdu_start_o,
    output logic [3:0]  mdu_op_o,
    output logic [31:0] mdu_in1_o,
    output logic [31:0] mdu_in2_o,
    output logic        busy_o,
    output logic        stall_o,
    output logic        div0_o,
    output logic        err_o
);

    logic [1:0]       state;
    logic [3:0]       op_q;
    logic [31:0]      in1_q;
    logic [31:0]      in2_q;
    logic             start_q;
    logic             div0_q;
    logic             err_q;
    logic             accept;
    logic             mt_fwd;
    logic             cnt_load;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_T - 1);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_T - 1);

    // Decode what the E-stage instruction asks for this cycle.
    always_comb begin
        accept   = 1'b0;
        mt_fwd   = 1'b0;
        if ((state == ST_IDLE) && e_valid_i) begin
            accept = is_mul(e_op_i) || is_div(e_op_i);
            mt_fwd = is_mt(e_op_i);
        end
    end

    // Load the counter on the ISSUE->RUN edge; op_q still holds the op.
    always_comb begin
        cnt_load = (state == ST_ISSUE);
        cnt_val  = is_div(op_q) ? DIV_LD : MULT_LD;
    end

    mdu_lat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (state == ST_RUN),
        .zero     (cnt_zero)
    );

    // FSM, registered MDU request outputs and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            op_q    <= OP_NONE;
            in1_q   <= '0;
            in2_q   <= '0;
            start_q <= 1'b0;
            div0_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            op_q    <= OP_NONE;
            in1_q   <= '0;
            in2_q   <= '0;
            start_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state   <= ST_ISSUE;
                        start_q <= 1'b1;
                        op_q    <= e_op_i;
                        in1_q   <= e_rs_i;
                        in2_q   <= e_rt_i;
                        if (is_div(e_op_i) && (e_rt_i == '0)) begin
                            div0_q <= 1'b1;
                        end
                    end else if (mt_fwd) begin
                        op_q  <= e_op_i;
                        in1_q <= e_rs_i;
                    end
                end
                ST_ISSUE: state <= ST_RUN;
                ST_RUN: begin
                    if (cnt_zero) begin
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
            if ((state != ST_IDLE) && e_valid_i && is_md(e_op_i)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mdu_start_o = start_q;
    assign mdu_op_o    = op_q;
    assign mdu_in1_o   = in1_q;
    assign mdu_in2_o   = in2_q;
    assign busy_o      = (state != ST_IDLE);
    assign stall_o     = !reset && d_md_i && (busy_o || accept);
    assign div0_o      = div0_q;
    assign err_o       = err_q;

endmodule
